// File: rtl/zclk_monitor.sv
// zclk_monitor: returned Z80 clock sync, edge strobes, period/speed classify, stall and loop-phase check; option ZCLK_MON_DEGLITCH_EN adds a 2-sample glitch filter
module zclk_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W = 6,
  parameter int TIMEOUT = 48,
  parameter int PHASE_WIN = 5
) (
  input  logic fclk,
  input  logic rst,
  input  logic zclk_in,
  input  logic zclk_out_ref,
  input  logic err_clr,
  output logic rx_pos,
  output logic rx_neg,
  output logic [CNT_W-1:0] period,
  output logic [1:0] speed,
  output logic speed_vld,
  output logic stalled,
  output logic phase_err
);
`ifdef ZCLK_MON_DEGLITCH_EN
  localparam int WIN = PHASE_WIN + 1;
`else
  localparam int WIN = PHASE_WIN;
`endif
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] TO_M1 = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] WIN_M1 = CNT_W'(WIN - 1);
  logic [SYNC_STAGES-1:0] sync;
  logic s, s_d, rise, fall, any_edge;
  logic [CNT_W-1:0] count, idle, win, p_new;
  logic [1:0] cand, c_new, rel_cnt;
  logic have_ref, r, r_d, armed, exp_rise;
  logic ref_rise, ref_fall, ref_edge, match, expire, err, supp;
  // shift the asynchronous returned clock through the synchronizer chain
  always_ff @(posedge fclk or posedge rst)
    if (rst) sync <= '0;
    else sync <= {sync[SYNC_STAGES-2:0], zclk_in};
`ifdef ZCLK_MON_DEGLITCH_EN
  // take a new level only once the last two synchronized samples agree
  always_ff @(posedge fclk or posedge rst)
    if (rst) s <= 1'b0;
    else if (sync[SYNC_STAGES-1] == sync[SYNC_STAGES-2]) s <= sync[SYNC_STAGES-1];
`else
  assign s = sync[SYNC_STAGES-1];
`endif
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;
  assign any_edge = rise | fall;
  assign p_new = (count == CMAX) ? CMAX : count + CNT_W'(1);
  assign c_new = (p_new == CNT_W'(2)) ? 2'b10 : (p_new == CNT_W'(4)) ? 2'b01 : (p_new == CNT_W'(8)) ? 2'b00 : 2'b11;
  assign ref_rise = r & ~r_d;
  assign ref_fall = ~r & r_d;
  assign ref_edge = ref_rise | ref_fall;
  assign match = armed & (exp_rise ? rise : fall);
  assign expire = armed & ~match & (win == WIN_M1);
  assign err = (any_edge & ~match) | expire | (ref_edge & armed & ~match);
  assign supp = stalled | (rel_cnt != 2'd2);
  // last level and registered edge strobes
  always_ff @(posedge fclk or posedge rst)
    if (rst) begin
      s_d <= 1'b0;
      rx_pos <= 1'b0;
      rx_neg <= 1'b0;
    end else begin
      s_d <= s;
      rx_pos <= rise;
      rx_neg <= fall;
    end
  // period measurement, speed classification and stall detection
  always_ff @(posedge fclk or posedge rst)
    if (rst) begin
      count <= '0;
      idle <= '0;
      period <= '0;
      cand <= 2'b11;
      speed <= 2'b11;
      speed_vld <= 1'b0;
      stalled <= 1'b0;
      have_ref <= 1'b0;
    end else begin
      count <= rise ? '0 : (count == CMAX) ? count : count + CNT_W'(1);
      idle <= any_edge ? '0 : (idle == CMAX) ? idle : idle + CNT_W'(1);
      if (rise) have_ref <= 1'b1;
      if (rise && have_ref) begin
        period <= p_new;
        cand <= c_new;
        if (c_new == cand) begin
          speed_vld <= (c_new != 2'b11);
          if (c_new != 2'b11) speed <= c_new;
        end
      end
      if (any_edge) stalled <= 1'b0;
      else if (idle == TO_M1) begin
        stalled <= 1'b1;
        speed_vld <= 1'b0;
        speed <= 2'b11;
        cand <= 2'b11;
        have_ref <= 1'b0;
      end
    end
  // loop checker: each reference edge expects the opposite returned edge within the window
  always_ff @(posedge fclk or posedge rst)
    if (rst) begin
      r <= 1'b0;
      r_d <= 1'b0;
      armed <= 1'b0;
      exp_rise <= 1'b0;
      win <= '0;
      rel_cnt <= 2'd0;
      phase_err <= 1'b0;
    end else begin
      r <= zclk_out_ref;
      r_d <= r;
      rel_cnt <= (rel_cnt == 2'd2) ? rel_cnt : rel_cnt + 2'd1;
      if (ref_edge) begin
        armed <= 1'b1;
        exp_rise <= ref_fall;
        win <= '0;
      end else if (match || expire) armed <= 1'b0;
      else if (armed) win <= win + CNT_W'(1);
      phase_err <= (err && !supp) ? 1'b1 : err_clr ? 1'b0 : phase_err;
    end
endmodule

// File: tb/tb_zclk_monitor.sv
// tb_zclk_monitor: scoreboard bench for zclk_monitor strobes, period, speed, stall and loop check
`timescale 1ns/1ps
module tb_zclk_monitor;
  localparam int SS = 2;
`ifdef ZCLK_MON_DEGLITCH_EN
  localparam int LAT = SS + 1;
  localparam int GLITCH_NEG = 0;
`else
  localparam int LAT = SS;
  localparam int GLITCH_NEG = 1;
`endif
  typedef struct {int c; int per; int spd; int vld;} exp_t;
  logic fclk = 1'b0, rst = 1'b1, zin = 1'b0, zref = 1'b0, err_clr = 1'b0;
  logic rx_pos, rx_neg, speed_vld, stalled, phase_err;
  logic [5:0] period;
  logic [1:0] speed;
  logic seen_err = 1'b0;
  bit ph = 1'b0;
  int cyc = 0, checks = 0, errors = 0;
  exp_t sb[$];

  zclk_monitor #(.SYNC_STAGES(SS), .CNT_W(6), .TIMEOUT(48), .PHASE_WIN(5)) dut (
    .fclk(fclk), .rst(rst), .zclk_in(zin), .zclk_out_ref(zref), .err_clr(err_clr),
    .rx_pos(rx_pos), .rx_neg(rx_neg), .period(period), .speed(speed),
    .speed_vld(speed_vld), .stalled(stalled), .phase_err(phase_err)
  );

  always #5 fclk = ~fclk;
  always @(posedge fclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic push(input int per, input int spd, input int vld);
    exp_t e;
    e.c = cyc + 1 + LAT;
    e.per = per;
    e.spd = spd;
    e.vld = vld;
    sb.push_back(e);
  endtask

  task automatic cycle_p(input int p, input int per, input int spd, input int vld);
    @(negedge fclk);
    zin = 1'b1;
    push(per, spd, vld);
    repeat (p / 2) @(negedge fclk);
    zin = 1'b0;
    repeat (p / 2 - 1) @(negedge fclk);
  endtask

  task automatic loop_run(input int n, input bit inv, input bit clr);
    logic nz;
    for (int i = 0; i < n; i++) begin
      @(negedge fclk);
      nz = inv ? ~zref : zref;
      if (nz && !zin) push(-1, -1, -1);
      zin = nz;
      err_clr = clr;
      if (ph) zref = ~zref;
      ph = ~ph;
      seen_err = seen_err | phase_err;
    end
  endtask

  always @(negedge fclk) begin : mon
    exp_t e;
    if (!rst && rx_pos) begin
      if (sb.size() == 0) chk("rx_pos_unexp", int'(rx_pos), 0);
      else begin
        e = sb.pop_front();
        chk("pos_cyc", cyc, e.c);
        if (e.per >= 0) chk("period", int'(period), e.per);
        if (e.spd >= 0) chk("speed", int'(speed), e.spd);
        if (e.vld >= 0) chk("speed_vld", int'(speed_vld), e.vld);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge fclk);
    chk("rst_rx_pos", int'(rx_pos), 0);
    chk("rst_period", int'(period), 0);
    chk("rst_speed", int'(speed), 3);
    chk("rst_vld", int'(speed_vld), 0);
    chk("rst_stalled", int'(stalled), 0);
    chk("rst_perr", int'(phase_err), 0);
    rst = 1'b0;
    repeat (3) @(negedge fclk);
    cycle_p(8, 0, 3, 0);
    cycle_p(8, 8, 3, 0);
    cycle_p(8, 8, 0, 1);
    cycle_p(8, 8, 0, 1);
    cycle_p(4, 8, 0, 1);
    cycle_p(4, 4, 0, 1);
    cycle_p(4, 4, 1, 1);
    cycle_p(4, 4, 1, 1);
    @(negedge fclk);
    zin = 1'b1;
    push(4, 1, 1);
    repeat (LAT + 48) @(negedge fclk);
    chk("stall_early", int'(stalled), 0);
    @(negedge fclk);
    chk("stall_set", int'(stalled), 1);
    chk("stall_speed", int'(speed), 3);
    chk("stall_vld", int'(speed_vld), 0);
    repeat (9) @(negedge fclk);
    zin = 1'b0;
    repeat (LAT + 1) @(negedge fclk);
    chk("resume_neg", int'(rx_neg), 1);
    chk("stall_clr", int'(stalled), 0);
    cycle_p(2, 4, 3, 0);
    cycle_p(2, 2, 3, 0);
    cycle_p(2, 2, 2, 1);
    cycle_p(2, 2, 2, 1);
    repeat (4) @(negedge fclk);
    chk("sb_empty_speed", sb.size(), 0);
    loop_run(20, 1'b1, 1'b0);
    loop_run(1, 1'b1, 1'b1);
    seen_err = 1'b0;
    loop_run(200, 1'b1, 1'b0);
    chk("perr_hold", int'(seen_err), 0);
    seen_err = 1'b0;
    loop_run(12, 1'b0, 1'b0);
    chk("perr_set", int'(seen_err), 1);
    repeat (20) begin
      @(negedge fclk);
      zin = 1'b0;
      err_clr = 1'b0;
    end
    @(negedge fclk);
    err_clr = 1'b1;
    @(negedge fclk);
    err_clr = 1'b0;
    chk("perr_clr", int'(phase_err), 0);
    chk("sb_empty_loop", sb.size(), 0);
    @(negedge fclk);
    zin = 1'b1;
    if (GLITCH_NEG != 0) push(-1, -1, -1);
    @(negedge fclk);
    zin = 1'b0;
    repeat (LAT + 1) @(negedge fclk);
    chk("glitch_neg", int'(rx_neg), GLITCH_NEG);
    repeat (3) @(negedge fclk);
    chk("sb_empty_glitch", sb.size(), 0);
    cycle_p(4, -1, -1, -1);
    cycle_p(4, -1, -1, -1);
    cycle_p(4, -1, -1, -1);
    repeat (2) @(negedge fclk);
    #2 rst = 1'b1;
    #1;
    chk("arst_rx_pos", int'(rx_pos), 0);
    chk("arst_rx_neg", int'(rx_neg), 0);
    chk("arst_period", int'(period), 0);
    chk("arst_speed", int'(speed), 3);
    chk("arst_vld", int'(speed_vld), 0);
    chk("arst_stalled", int'(stalled), 0);
    chk("arst_perr", int'(phase_err), 0);
    chk("sb_empty_rst", sb.size(), 0);
    @(negedge fclk);
    rst = 1'b0;
    @(negedge fclk);
    chk("rel_rx_pos", int'(rx_pos), 0);
    cycle_p(4, 0, 3, 0);
    cycle_p(4, 4, 3, 0);
    cycle_p(4, 4, 1, 1);
    cycle_p(4, 4, 1, 1);
    repeat (4) @(negedge fclk);
    chk("sb_empty_end", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/zclk_monitor.md
Name: zclk_monitor

Overview:
- Receive side of the Z80 clock loop. Samples the buffered zclk returned from the board into the fclk domain.
- Produces registered edge strobes rx_pos/rx_neg and measures the Z80 clock period in fclk cycles.
- Classifies the period as 3.5/7/14 MHz, detects a stopped clock, and checks each generated zclk_out edge against its returned, externally inverted edge.
- Used by the bus-timing logic and the debug/status registers.

Parameters:
- SYNC_STAGES, 2: synchronizer flops on zclk_in; legal values 2..3.
- CNT_W, 6: width of the period counter and the idle counter.
- TIMEOUT, 48: number of fclk cycles with no returned edge before stalled is asserted; must be less than 2^CNT_W.
- PHASE_WIN, 5: fclk cycles allowed from a reference edge to the matching returned edge.

Ports:
- fclk  in  1  28 MHz system clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- zclk_in  in  1  Z80 clock returned from the board; asynchronous to fclk.
- zclk_out_ref  in  1  internally generated zclk_out, before the external inverter; changes on negedge fclk.
- err_clr  in  1  clears phase_err; one fclk pulse.
- rx_pos  out  1  one-cycle strobe, rising edge of the returned clock.
- rx_neg  out  1  one-cycle strobe, falling edge of the returned clock.
- period  out  CNT_W  last complete rise-to-rise period, in fclk cycles.
- speed  out  2  00=3.5 MHz, 01=7 MHz, 10=14 MHz, 11=unknown.
- speed_vld  out  1  speed is confirmed.
- stalled  out  1  no returned edge for TIMEOUT cycles.
- phase_err  out  1  sticky loop-mismatch flag.

Behaviour:
- Reset values: rx_pos=0, rx_neg=0, period=0, speed=11, speed_vld=0, stalled=0, phase_err=0. The synchronizer flops, the last-level register, all counters and the checker all reset to 0 / disarmed.
- Synchronizer and edge detect:
  - zclk_in passes through SYNC_STAGES flops. s is the last stage; s_d is s delayed by one fclk.
  - rx_pos = registered (s & ~s_d); rx_neg = registered (~s & s_d).
  - A zclk_in change that meets setup at posedge N gives a strobe that is high for exactly the one cycle after posedge N+SYNC_STAGES.
  - After reset, s_d=0, so a returned level of 1 produces one rx_pos. This is intended.
- Period counter:
  - Increments every fclk and saturates at 2^CNT_W-1.
  - On a rising edge (the cycle rx_pos is computed): period <= count+1, then count <= 0.
  - The first rise after reset, and the first rise after stalled deasserts, only restarts the count; period is not updated.
- Classifier:
  - Class for each period update: 2 -> 10, 4 -> 01, 8 -> 00, any other value -> 11. Stretched (stalled) cycles therefore classify as 11.
  - A candidate class is held internally. When two consecutive period updates give the same class, speed <= that class.
  - speed_vld <= 1 only if that class is not 11. Otherwise speed_vld <= 0 and speed holds its last value.
  - Example: a turbo change with sequence 8,8,4,4 gives speed 00 then 01. The value 01 is visible on the cycle after the second 4.
- Idle counter:
  - Cleared on any returned edge; otherwise increments, saturating.
  - When it reaches TIMEOUT: stalled <= 1, speed_vld <= 0, speed <= 11, and the classifier candidate resets to 11.
  - stalled clears on the next returned edge of either polarity.
- Phase checker:
  - zclk_out_ref is registered into r and r_d at posedge fclk.
  - A fall of r arms the checker expecting a returned rise; a rise of r arms it expecting a returned fall (external inversion).
  - An armed window counter counts up to PHASE_WIN.
  - A returned edge of the expected polarity inside the window disarms the checker.
  - phase_err <= 1 on any of these:
    - window expiry;
    - a returned edge of the wrong polarity;
    - a returned edge while disarmed;
    - a new reference edge while still armed. In this case the checker re-arms for the new edge.
  - While stalled=1 or within 2 cycles after reset release, checker errors are suppressed (no phase_err set).
  - If err_clr and an error occur in the same cycle, the error wins.
- Reset mid-operation: all state returns to reset values immediately and asynchronously. No strobe is emitted on the cycle reset deasserts.

Optional Feature:
- ZCLK_MON_DEGLITCH_EN defined:
  - A glitch filter follows the synchronizer. s only changes after the synchronized input holds its new level for 2 consecutive fclk cycles.
  - Strobe latency grows by 1 cycle. Single-cycle pulses on zclk_in produce no strobe.
  - The checker window becomes PHASE_WIN+1.
- Not defined: no filter; latency and window are as stated in Behaviour.

Test Plan:
- 3.5 MHz: zclk_in toggles every 4 fclk -> rx_pos every 8 cycles, period=8, speed=00. speed_vld=1 on the cycle after the 2nd period update (the 3rd rising edge).
- Turbo switch: periods 8,8,4,4,4 -> speed stays 00 through the first 4; becomes 01 after the second 4; speed_vld never drops.
- Stop: hold zclk_in=1 for 60 cycles with TIMEOUT=48 -> stalled=1 and speed=11 at idle count 48. Resume toggling every 2 cycles -> stalled clears on the first edge; the first period is discarded; speed=10 after two periods of 2.
- Loop match: zclk_in = ~zclk_out_ref delayed 1 fclk at 7 MHz for 200 cycles -> phase_err stays 0. Force zclk_in = zclk_out_ref (no inversion) -> phase_err=1 within PHASE_WIN cycles. err_clr pulse with no error in that cycle -> phase_err=0.
- Glitch: 1-cycle high pulse on a low zclk_in -> one rx_pos/rx_neg pair without the macro; none with ZCLK_MON_DEGLITCH_EN.
- Async reset asserted mid-period at 7 MHz -> all outputs return to reset values within the same cycle. After release the next period is discarded, with speed=11 and speed_vld=0 until two matching periods.
